regfile_wb_arb: RTL

Write-port arbiter for the register file: shares the single register-file write port between `NREQ` writeback requesters (ALU, load unit, multiply/divide, …) using a valid/ready handshake and round-robin priority. The accepted write is staged in an output register and driven onto the register file's `regwrite`/`wreg`/`wdata` one cycle later. An optional bypass port lets the decode stage see the staged write before it commits.

---
 rtl/regfile_wb_arb.sv | 77 +++++++
 1 files changed

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: round-robin arbiter for the register-file write port with a registered output stage; REGFILE_WB_FWD_EN enables the bypass comparators
module regfile_wb_arb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREQ  = 3,
  localparam int ADDR = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR-1:0]   req_wreg,
  input  logic [NREQ*WIDTH-1:0]  req_wdata,
  output logic                   regwrite,
  output logic [ADDR-1:0]        wreg,
  output logic [WIDTH-1:0]       wdata,
  input  logic [ADDR-1:0]        fwd_reg1,
  input  logic [ADDR-1:0]        fwd_reg2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [WIDTH-1:0]       fwd_data1,
  output logic [WIDTH-1:0]       fwd_data2
);
  localparam int LW = $clog2(NREQ);
  logic [LW-1:0] last, gnt, idx;
  logic found;
  logic xfer;
  logic [ADDR-1:0] sel_wreg;
  logic [WIDTH-1:0] sel_wdata;
  // search from last+1 upward with wrap; the nearest valid requester wins
  always_comb begin
    gnt = last;
    idx = last;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = LW'((int'(last) + k) % NREQ);
      if (req_valid[idx]) begin
        gnt = idx;
        found = 1'b1;
      end
    end
    req_ready = (found && !hold && !reset) ? (NREQ'(1) << gnt) : '0;
  end
  assign xfer = |req_ready;
  assign sel_wreg = req_wreg[int'(gnt)*ADDR +: ADDR];
  assign sel_wdata = req_wdata[int'(gnt)*WIDTH +: WIDTH];
  // stage the granted write; register 0 completes the handshake but never writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= LW'(NREQ - 1);
      regwrite <= 1'b0;
      wreg <= '0;
      wdata <= '0;
    end else if (xfer) begin
      last <= gnt;
      regwrite <= sel_wreg != '0;
      wreg <= sel_wreg;
      wdata <= sel_wdata;
    end else begin
      regwrite <= 1'b0;
    end
  end
`ifdef REGFILE_WB_FWD_EN
  assign fwd_hit1 = regwrite && (wreg == fwd_reg1) && (fwd_reg1 != '0);
  assign fwd_hit2 = regwrite && (wreg == fwd_reg2) && (fwd_reg2 != '0);
  assign fwd_data1 = fwd_hit1 ? wdata : '0;
  assign fwd_data2 = fwd_hit2 ? wdata : '0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_reg1, fwd_reg2};
  assign fwd_hit1 = 1'b0;
  assign fwd_hit2 = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif
endmodule
